// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the reg_file_sb register file and scoreboard.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write-to-read forwarding).
package reg_file_pkg;

   localparam int unsigned XLEN_DEF  = 64;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned NRD_DEF   = 2;
   localparam int unsigned NWR_DEF   = 2;
   localparam int unsigned ZERO_REG  = 0;
   localparam int unsigned MAX_PORTS = 4;

   // Index of the highest set bit; callers qualify the result with |match.
   function automatic int unsigned hi_match_idx(input logic [MAX_PORTS-1:0] match);
      hi_match_idx = 0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         if (match[i]) hi_match_idx = i;
      end
   endfunction

endpackage

// File: rtl/reg_file_fwd.sv
// Per-read-port output mux: stored value, or the highest-index same-cycle write when
// REG_FILE_BYPASS_EN is defined. Without the macro it is a plain gated storage read.
module reg_file_fwd
   import reg_file_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = 5,
   parameter int unsigned NWR  = NWR_DEF
) (
   input  logic               i_rd_en,
   input  logic [AW-1:0]      i_rd_addr,
   input  logic [XLEN-1:0]    i_st_data,
   input  logic               i_st_busy,
   input  logic [NWR-1:0]     i_wr_en,
   input  logic [NWR*AW-1:0]  i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   output logic [XLEN-1:0]    o_rd_data,
   output logic               o_rd_busy
);

`ifdef REG_FILE_BYPASS_EN
   logic [MAX_PORTS-1:0] w_match;
   logic [XLEN-1:0]      w_hit_data;
   logic                 w_hit;

   always_comb begin
      w_match = '0;
      for (int unsigned p = 0; p < NWR; p++) begin
         w_match[p] = i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_rd_addr);
      end
      w_hit      = (|w_match) && (i_rd_addr != AW'(ZERO_REG));
      w_hit_data = i_wr_data[hi_match_idx(w_match)*XLEN +: XLEN];
   end

   always_comb begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
      if (i_rd_en) begin
         if (w_hit) begin
            o_rd_data = w_hit_data;
         end else begin
            o_rd_data = i_st_data;
            o_rd_busy = i_st_busy;
         end
      end
   end
`else
   logic w_unused_wr;

   assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};
   assign o_rd_data   = i_rd_en ? i_st_data : '0;
   assign o_rd_busy   = i_rd_en & i_st_busy;
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with per-register busy scoreboard; reg 0 reads zero.
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read and write-to-issue forwarding).
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = $clog2(NREGS),
   parameter int unsigned NRD   = NRD_DEF,
   parameter int unsigned NWR   = NWR_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_addr,
   output logic                iss_ready,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   output logic [AW:0]         busy_cnt
);

   logic [XLEN-1:0]  r_regs [1:NREGS-1];
   logic [NREGS-1:1] r_busy;
   logic [AW:0]      r_busy_cnt;

   logic [XLEN-1:0]  w_regs [NREGS];
   logic [NREGS-1:0] w_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [AW:0]      w_cnt_nxt;
   logic             w_iss_free;

   assign w_regs[0] = '0;
   for (genvar g = 1; g < NREGS; g++) begin : g_view
      assign w_regs[g] = r_regs[g];
   end
   assign w_busy = {r_busy, 1'b0};

`ifdef REG_FILE_BYPASS_EN
   logic w_iss_wr_hit;

   always_comb begin
      w_iss_wr_hit = 1'b0;
      for (int unsigned p = 0; p < NWR; p++) begin
         if (wr_en[p] && (wr_addr[p*AW +: AW] == iss_addr)) w_iss_wr_hit = 1'b1;
      end
   end

   assign w_iss_free = (iss_addr == AW'(ZERO_REG)) || !w_busy[iss_addr] || w_iss_wr_hit;
`else
   assign w_iss_free = (iss_addr == AW'(ZERO_REG)) || !w_busy[iss_addr];
`endif

   assign iss_ready = iss_valid && w_iss_free;

   // Clears first, then the issue set, so a same-cycle set on the same register wins.
   always_comb begin
      w_busy_nxt = w_busy;
      for (int unsigned p = 0; p < NWR; p++) begin
         if (wr_en[p]) w_busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
      end
      if (iss_ready && (iss_addr != AW'(ZERO_REG))) w_busy_nxt[iss_addr] = 1'b1;
      w_busy_nxt[ZERO_REG] = 1'b0;
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 1; i < NREGS; i++) r_regs[i] <= '0;
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         // Ascending port scan: the last matching assignment (highest port) takes effect.
         for (int unsigned i = 1; i < NREGS; i++) begin
            for (int unsigned p = 0; p < NWR; p++) begin
               if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(i))) begin
                  r_regs[i] <= wr_data[p*XLEN +: XLEN];
               end
            end
         end
         r_busy     <= w_busy_nxt[NREGS-1:1];
         r_busy_cnt <= w_cnt_nxt;
      end
   end

   assign busy_cnt = r_busy_cnt;

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      reg_file_fwd #(
         .XLEN (XLEN),
         .AW   (AW),
         .NWR  (NWR)
      ) u_fwd (
         .i_rd_en   (rd_en[g]),
         .i_rd_addr (rd_addr[g*AW +: AW]),
         .i_st_data (w_regs[rd_addr[g*AW +: AW]]),
         .i_st_busy (w_busy[rd_addr[g*AW +: AW]]),
         .i_wr_en   (wr_en),
         .i_wr_addr (wr_addr),
         .i_wr_data (wr_data),
         .o_rd_data (rd_data[g*XLEN +: XLEN]),
         .o_rd_busy (rd_busy[g])
      );
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_valid;
   logic [AW-1:0]       iss_addr;
   logic                iss_ready;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [AW:0]         busy_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   bit [XLEN-1:0] m_regs [NREGS];
   bit            m_busy [NREGS];

   reg_file_sb #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic idle();
      rd_en = '0; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
      wr_en = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic set_rd(input int p, input bit en, input int a);
      rd_en[p] = en;
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input bit en, input int a, input logic [XLEN-1:0] d);
      wr_en[p] = en;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   function automatic bit wr_hits(input logic [AW-1:0] a);
      wr_hits = 1'b0;
      for (int q = 0; q < NWR; q++) if (wr_en[q] && wr_addr[q*AW +: AW] == a) wr_hits = 1'b1;
   endfunction

   function automatic logic [XLEN-1:0] wr_last(input logic [AW-1:0] a);
      wr_last = '0;
      for (int q = 0; q < NWR; q++) if (wr_en[q] && wr_addr[q*AW +: AW] == a) wr_last = wr_data[q*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input int p);
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      if (!rd_en[p]) return '0;
      if (BYP && a != 0 && wr_hits(a)) return wr_last(a);
      return m_regs[a];
   endfunction

   function automatic bit exp_busy(input int p);
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      if (!rd_en[p]) return 1'b0;
      if (BYP && a != 0 && wr_hits(a)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic bit exp_ready();
      return iss_valid && (iss_addr == 0 || !m_busy[iss_addr] || (BYP && wr_hits(iss_addr)));
   endfunction

   function automatic int model_count();
      model_count = 0;
      for (int i = 0; i < NREGS; i++) model_count += int'(m_busy[i]);
   endfunction

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREGS - 1));
   endfunction

   task automatic check_outputs();
      for (int p = 0; p < NRD; p++) begin
         check($sformatf("rd_data%0d", p), rd_data[p*XLEN +: XLEN], exp_data(p));
         check($sformatf("rd_busy%0d", p), rd_busy[p], exp_busy(p));
      end
      check("iss_ready", iss_ready, exp_ready());
      check("busy_cnt", busy_cnt, model_count());
   endtask

   // Checks combinational outputs mid-cycle, then advances the model across one edge.
   task automatic step();
      bit [XLEN-1:0] n_regs [NREGS];
      bit            n_busy [NREGS];
      bit            acc;
      logic [AW-1:0] a;
      @(negedge clk);
      check_outputs();
      n_regs = m_regs;
      n_busy = m_busy;
      acc = exp_ready();
      for (int q = 0; q < NWR; q++) begin
         a = wr_addr[q*AW +: AW];
         if (wr_en[q] && a != 0) begin
            n_regs[a] = wr_data[q*XLEN +: XLEN];
            n_busy[a] = 1'b0;
         end
      end
      if (acc && iss_addr != 0) n_busy[iss_addr] = 1'b1;
      @(posedge clk);
      m_regs = n_regs;
      m_busy = n_busy;
      #1;
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      #2;
      check("rst_cnt", busy_cnt, 0);
      set_rd(0, 1, 5);
      iss_valid = 1'b1; iss_addr = 3;
      #1;
      check("rst_rd", rd_data[XLEN-1:0], 0);
      check("rst_rdy", iss_ready, 1);
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // zero register
      set_wr(0, 1, 0, 64'hDEAD);
      step();
      idle();
      set_rd(0, 1, 0);
      iss_valid = 1'b1; iss_addr = 0;
      #1;
      check("zero_rd", rd_data[XLEN-1:0], 0);
      check("zero_iss1", iss_ready, 1);
      step();
      check("zero_iss2", iss_ready, 1);
      step();
      check("zero_cnt", busy_cnt, 0);
      idle();

      // scoreboard hazard and retry
      iss_valid = 1'b1; iss_addr = 7;
      step();
      check("sb_retry_rdy", iss_ready, 0);
      check("sb_cnt", busy_cnt, 1);
      step();
      iss_valid = 1'b0;
      set_wr(0, 1, 7, 64'h1234);
      step();
      set_wr(0, 0, 0, '0);
      iss_valid = 1'b1; iss_addr = 7;
      set_rd(1, 1, 7);
      #1;
      check("sb_acc", iss_ready, 1);
      check("sb_rd", rd_data[2*XLEN-1:XLEN], 64'h1234);
      step();
      idle();
      set_wr(0, 1, 7, 64'h55);
      step();
      idle();

      // same-address write conflict
      set_wr(0, 1, 3, 64'h11);
      set_wr(1, 1, 3, 64'h22);
      step();
      idle();
      set_rd(0, 1, 3);
      #1;
      check("wconf_rd", rd_data[XLEN-1:0], 64'h22);
      step();
      idle();

      // set vs clear on one register
      iss_valid = 1'b1; iss_addr = 9;
      step();
      set_wr(0, 1, 9, 64'h99);
      #1;
      check("sc_rdy", iss_ready, BYP);
      step();
      idle();
      set_rd(0, 1, 9);
      #1;
      check("sc_busy", rd_busy[0], BYP);
      check("sc_cnt", busy_cnt, BYP ? 1 : 0);
      step();
      set_wr(0, 1, 9, 64'h9A);
      step();
      idle();

      // bypass visibility
      set_wr(1, 1, 4, 64'hBEEF);
      set_rd(1, 1, 4);
      #1;
      check("byp_rd", rd_data[2*XLEN-1:XLEN], BYP ? 64'hBEEF : 64'h0);
      check("byp_busy", rd_busy[1], 0);
      step();
      set_wr(1, 0, 0, '0);
      #1;
      check("byp_next", rd_data[2*XLEN-1:XLEN], 64'hBEEF);
      step();
      idle();

      // all registers busy
      for (int r = 1; r < NREGS; r++) begin
         iss_valid = 1'b1; iss_addr = AW'(r);
         step();
      end
      iss_addr = 12;
      #1;
      check("full_rdy", iss_ready, 0);
      check("full_cnt", busy_cnt, NREGS - 1);
      step();
      idle();
      for (int r = 1; r < NREGS; r += 2) begin
         set_wr(0, 1, r, 64'(r) << 8);
         if (r + 1 < NREGS) set_wr(1, 1, r + 1, 64'(r + 1) << 8);
         else set_wr(1, 0, 0, '0);
         step();
      end
      idle();
      step();
      check("empty_cnt", busy_cnt, 0);

      // asynchronous reset mid-run
      set_wr(0, 1, 5, 64'hAA);
      step();
      idle();
      iss_valid = 1'b1; iss_addr = 5;
      step();
      idle();
      set_rd(0, 1, 5);
      iss_valid = 1'b1; iss_addr = 5;
      #1;
      check("pre_rst_rd", rd_data[XLEN-1:0], 64'hAA);
      check("pre_rst_busy", rd_busy[0], 1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_rd", rd_data[XLEN-1:0], 0);
      check("mid_rst_busy", rd_busy[0], 0);
      check("mid_rst_cnt", busy_cnt, 0);
      check("mid_rst_rdy", iss_ready, 1);
      model_reset();
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // randomized traffic
      repeat (600) begin
         for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 3) != 0, int'(pick_addr()));
         for (int q = 0; q < NWR; q++)
            set_wr(q, $urandom_range(0, 2) == 0, int'(pick_addr()), {$urandom, $urandom});
         iss_valid = 1'(($urandom_range(0, 1)));
         iss_addr  = pick_addr();
         step();
      end
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
